// File: rtl/deduplicator.sv
// Collapses each duplicated pair of stream beats into one output beat.
// Checks that pair data matches and realigns pairing on start-of-frame.
module deduplicator #(
  parameter int DATA_W  = 4,
  parameter int USER_W  = 2,
  parameter int CNT_W   = 8,
  parameter bit COMPARE = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] i_TDATA,
  input  logic              i_TVALID,
  input  logic [USER_W-1:0] i_TUSER,
  output logic              o_TREADY,
  output logic [DATA_W-1:0] o_TDATA,
  output logic              o_TVALID,
  output logic [USER_W-1:0] o_TUSER,
  input  logic              i_TREADY,
  output logic              o_MISMATCH,
  output logic              o_ORPHAN,
  output logic [CNT_W-1:0]  o_ERR_CNT
);

  // state     | meaning
  // ST_FIRST  | waiting for the first beat of a pair
  // ST_SECOND | first beat held in a_data/a_user, waiting for its partner
  typedef enum logic {ST_FIRST, ST_SECOND} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] a_data;
  logic [USER_W-1:0] a_user;
  logic              acc, resync, load, drain, mis_evt, err_evt;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_FIRST;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_FIRST:  if (acc)  state_nxt = ST_SECOND;
      ST_SECOND: if (load) state_nxt = ST_FIRST;
      default:   state_nxt = ST_FIRST;
    endcase
  end

  always_comb begin
    o_TREADY = 1'b0;
    if (!reset) o_TREADY = (state == ST_FIRST) || !o_TVALID || i_TREADY;
  end

  assign acc     = i_TVALID && o_TREADY;
  // A new SOF arriving behind a non-SOF first beat means the pairing slipped.
  assign resync  = (state == ST_SECOND) && acc && i_TUSER[0] && !a_user[0];
  assign load    = (state == ST_SECOND) && acc && !resync;
  assign drain   = o_TVALID && i_TREADY;
  assign mis_evt = load && COMPARE && (a_data != i_TDATA);
  assign err_evt = mis_evt || resync;

  always_ff @(posedge clk) begin
    if (reset) begin
      a_data <= '0;
      a_user <= '0;
    end else if (acc && ((state == ST_FIRST) || resync)) begin
      a_data <= i_TDATA;
      a_user <= i_TUSER;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      o_TVALID <= 1'b0;
      o_TDATA  <= '0;
      o_TUSER  <= '0;
    end else if (load) begin
      o_TVALID <= 1'b1;
      o_TDATA  <= a_data;
      o_TUSER  <= a_user;
    end else if (drain) begin
      o_TVALID <= 1'b0;
      o_TDATA  <= '0;
      o_TUSER  <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      o_MISMATCH <= 1'b0;
      o_ORPHAN   <= 1'b0;
      o_ERR_CNT  <= '0;
    end else begin
      o_MISMATCH <= mis_evt;
      o_ORPHAN   <= resync;
      if (err_evt && (o_ERR_CNT != {CNT_W{1'b1}}))
        o_ERR_CNT <= o_ERR_CNT + 1'b1;
    end
  end

endmodule
